wave_window_plotter: RTL and testbench

WAVE_WINDOW_PLOTTER -- requirements
Module: wave_window_plotter

---
 rtl/wave_window_plotter.sv | 237 +++++++++++++++++++++++
 tb/tb_wave_window_plotter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/wave_window_plotter.sv
// wave_window_plotter: reduces a stereo audio stream to one plotted row per
// window of 2^WINDOW_LOG2 reads. Average modes report the window mean as a
// row around mid-height; peak mode reports the largest |mix| as a row
// measured up from the bottom of the plot. Each column is offered to a line
// drawer over a valid/ready handshake. A completed window that finds the
// output still occupied is dropped, and the sticky overrun flag records it.
`timescale 1ns/1ps

module wave_window_plotter #(
  parameter int DATA_W      = 24,
  parameter int WINDOW_LOG2 = 12,
  parameter int COLS        = 640,
  parameter int HEIGHT      = 480,
  parameter int GAIN_LOG2   = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     read,
  input  logic signed [DATA_W-1:0] audio_left,
  input  logic signed [DATA_W-1:0] audio_right,
  input  logic [1:0]               mode,
  output logic                     col_valid,
  input  logic                     col_ready,
  output logic [10:0]              col_x,
  output logic [10:0]              col_y,
  output logic                     frame_done,
  output logic                     overrun
);

  // Mix is one bit wider than a sample so that L+R cannot wrap before the halving.
  localparam int MIX_W = DATA_W + 1;
  // A full window of worst-case samples fits in the accumulator with headroom.
  localparam int ACC_W = DATA_W + WINDOW_LOG2 + 1;
  // Row arithmetic is wide enough to hold the gain shift and a sign bit.
  localparam int Y_W   = ACC_W + GAIN_LOG2 + 2;

  localparam logic [WINDOW_LOG2-1:0] CNT_LAST = {WINDOW_LOG2{1'b1}};
  localparam logic [WINDOW_LOG2-1:0] CNT_ZERO = {WINDOW_LOG2{1'b0}};
  localparam logic [WINDOW_LOG2-1:0] CNT_ONE  = WINDOW_LOG2'(1);
  localparam logic signed [Y_W-1:0]  HALF_H   = Y_W'(HEIGHT / 2);
  localparam logic signed [Y_W-1:0]  TOP_ROW  = Y_W'(HEIGHT - 1);
  localparam logic signed [Y_W-1:0]  ZERO_Y   = {Y_W{1'b0}};
  localparam logic [10:0]            LAST_COL = 11'(COLS - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  state_t                    state_q, state_d;
  logic [1:0]                mode_q, mode_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [MIX_W-1:0]          peak_q, peak_d;
  logic [WINDOW_LOG2-1:0]    cnt_q, cnt_d;
  logic                      col_valid_q, col_valid_d;
  logic [10:0]               col_x_q, col_x_d;
  logic [10:0]               col_y_q, col_y_d;
  logic                      frame_done_q, frame_done_d;
  logic                      overrun_q, overrun_d;

  logic [1:0]                eff_mode_s;
  logic signed [MIX_W-1:0]   sum_s;
  logic signed [MIX_W-1:0]   mix_s;
  logic [MIX_W-1:0]          mix_abs_s;
  logic signed [ACC_W-1:0]   samp_s;
  logic signed [ACC_W-1:0]   acc_sum_s;
  logic [MIX_W-1:0]          peak_max_s;
  logic signed [ACC_W-1:0]   avg_s;
  logic signed [Y_W-1:0]     avg_ext_s, avg_gain_s, avg_sh_s, y_avg_s;
  logic signed [Y_W-1:0]     pk_ext_s, pk_gain_s, pk_sh_s, y_pk_s;
  logic signed [Y_W-1:0]     y_raw_s, y_clamp_s;
  logic [10:0]               y_new_s;
  logic                      win_done_s;
  logic                      xfer_s;

  // Per-read sample formation and the row the window would produce if this read completes it.
  always_comb begin
    // The first read of a window uses the live mode input, which is also latched for the rest.
    eff_mode_s = (cnt_q == CNT_ZERO) ? mode : mode_q;
    sum_s      = MIX_W'(audio_left) + MIX_W'(audio_right);
    mix_s      = sum_s >>> 1;
    mix_abs_s  = mix_s[MIX_W-1] ? MIX_W'(-mix_s) : MIX_W'(mix_s);
    case (eff_mode_s)
      2'b01:   samp_s = ACC_W'(audio_left);
      2'b10:   samp_s = ACC_W'(audio_right);
      default: samp_s = ACC_W'(mix_s);
    endcase
    // Sum and peak both track every read; the mode only decides which one becomes the row.
    acc_sum_s  = acc_q + samp_s;
    peak_max_s = (mix_abs_s > peak_q) ? mix_abs_s : peak_q;
    avg_s      = acc_sum_s >>> WINDOW_LOG2;

    avg_ext_s  = Y_W'(avg_s);
    avg_gain_s = avg_ext_s <<< GAIN_LOG2;
    avg_sh_s   = avg_gain_s >>> (DATA_W - 8);
    y_avg_s    = HALF_H - avg_sh_s;

    pk_ext_s   = Y_W'(peak_max_s);
    pk_gain_s  = pk_ext_s <<< GAIN_LOG2;
    pk_sh_s    = pk_gain_s >>> (DATA_W - 9);
    y_pk_s     = TOP_ROW - pk_sh_s;

    if (eff_mode_s == 2'b11) begin
      y_raw_s = y_pk_s;
    end else begin
      y_raw_s = y_avg_s;
    end

    if (y_raw_s < ZERO_Y) begin
      y_clamp_s = ZERO_Y;
    end else if (y_raw_s > TOP_ROW) begin
      y_clamp_s = TOP_ROW;
    end else begin
      y_clamp_s = y_raw_s;
    end
    y_new_s = 11'(y_clamp_s);
  end

  // Window FSM: accumulate reads while enabled, detect the completing read, clear on abort.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    acc_d      = acc_q;
    peak_d     = peak_q;
    cnt_d      = cnt_q;
    win_done_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        acc_d  = {ACC_W{1'b0}};
        peak_d = {MIX_W{1'b0}};
        cnt_d  = CNT_ZERO;
        if (enable) begin
          state_d = ST_ACCUM;
          mode_d  = mode;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (!enable) begin
          // Dropping enable wins over a coincident completing read.
          state_d = ST_IDLE;
          acc_d   = {ACC_W{1'b0}};
          peak_d  = {MIX_W{1'b0}};
          cnt_d   = CNT_ZERO;
        end else if (read) begin
          if (cnt_q == CNT_ZERO) begin
            mode_d = mode;
          end else begin
            mode_d = mode_q;
          end
          if (cnt_q == CNT_LAST) begin
            win_done_s = 1'b1;
            acc_d      = {ACC_W{1'b0}};
            peak_d     = {MIX_W{1'b0}};
            cnt_d      = CNT_ZERO;
          end else begin
            acc_d  = acc_sum_s;
            peak_d = peak_max_s;
            cnt_d  = cnt_q + CNT_ONE;
          end
        end else begin
          state_d = ST_ACCUM;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Column handshake: transfer, column index advance, result load or drop with overrun.
  always_comb begin
    col_valid_d  = col_valid_q;
    col_x_d      = col_x_q;
    col_y_d      = col_y_q;
    overrun_d    = overrun_q;
    frame_done_d = 1'b0;
    xfer_s       = col_valid_q & col_ready;
    if (xfer_s) begin
      col_valid_d = 1'b0;
      if (col_x_q == LAST_COL) begin
        col_x_d      = 11'd0;
        frame_done_d = 1'b1;
      end else begin
        col_x_d      = col_x_q + 11'd1;
      end
    end else begin
      col_x_d = col_x_q;
    end
    if (win_done_s) begin
      if (!col_valid_q || xfer_s) begin
        col_valid_d = 1'b1;
        col_y_d     = y_new_s;
      end else begin
        overrun_d   = 1'b1;
      end
    end else begin
      col_y_d = col_y_q;
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      mode_q       <= 2'b00;
      acc_q        <= {ACC_W{1'b0}};
      peak_q       <= {MIX_W{1'b0}};
      cnt_q        <= CNT_ZERO;
      col_valid_q  <= 1'b0;
      col_x_q      <= 11'd0;
      col_y_q      <= 11'd0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      acc_q        <= acc_d;
      peak_q       <= peak_d;
      cnt_q        <= cnt_d;
      col_valid_q  <= col_valid_d;
      col_x_q      <= col_x_d;
      col_y_q      <= col_y_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign col_valid  = col_valid_q;
  assign col_x      = col_x_q;
  assign col_y      = col_y_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_wave_window_plotter.sv
// Directed bench for wave_window_plotter: 4-read windows, 4 columns per frame.
// A second instance with a x4 vertical gain sees the same stimulus to exercise clamping.
`timescale 1ns/1ps

module tb_wave_window_plotter;

  logic               clk;
  logic               reset;
  logic               enable;
  logic               read;
  logic signed [23:0] audio_left;
  logic signed [23:0] audio_right;
  logic [1:0]         mode;
  logic               col_ready;

  logic               col_valid, frame_done, overrun;
  logic [10:0]        col_x, col_y;
  logic               g_valid, g_frame_done, g_overrun;
  logic [10:0]        g_x, g_y;

  int errors = 0;
  int checks = 0;

  wave_window_plotter #(
    .DATA_W(24), .WINDOW_LOG2(2), .COLS(4), .HEIGHT(480), .GAIN_LOG2(0)
  ) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .read(read),
    .audio_left(audio_left), .audio_right(audio_right), .mode(mode),
    .col_valid(col_valid), .col_ready(col_ready), .col_x(col_x), .col_y(col_y),
    .frame_done(frame_done), .overrun(overrun)
  );

  wave_window_plotter #(
    .DATA_W(24), .WINDOW_LOG2(2), .COLS(4), .HEIGHT(480), .GAIN_LOG2(2)
  ) u_gain (
    .clk(clk), .reset(reset), .enable(enable), .read(read),
    .audio_left(audio_left), .audio_right(audio_right), .mode(mode),
    .col_valid(g_valid), .col_ready(col_ready), .col_x(g_x), .col_y(g_y),
    .frame_done(g_frame_done), .overrun(g_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One read strobe; returns on the falling edge right after the sampling edge.
  task automatic do_read(input logic [23:0] l, input logic [23:0] r);
    @(negedge clk);
    audio_left  = l;
    audio_right = r;
    read        = 1'b1;
    @(negedge clk);
    read        = 1'b0;
  endtask

  task automatic window4(input logic [23:0] l, input logic [23:0] r);
    for (int i = 0; i < 4; i++) do_read(l, r);
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; read = 1'b0; mode = 2'b00; col_ready = 1'b0;
    audio_left = 24'sd0; audio_right = 24'sd0;
    #12;
    check("rst_valid", {31'd0, col_valid}, 32'd0);
    check("rst_x", {21'd0, col_x}, 32'd0);
    check("rst_y", {21'd0, col_y}, 32'd0);
    check("rst_fd", {31'd0, frame_done}, 32'd0);
    check("rst_ovr", {31'd0, overrun}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    enable = 1'b1; col_ready = 1'b1; mode = 2'b00;

    // Window 1: mix-average of +2^22 -> 240-64 = 176; gain x4 clamps to 0.
    for (int i = 0; i < 3; i++) do_read(24'h400000, 24'h400000);
    check("w1_not_yet", {31'd0, col_valid}, 32'd0);
    do_read(24'h400000, 24'h400000);
    check("w1_valid", {31'd0, col_valid}, 32'd1);
    check("w1_x", {21'd0, col_x}, 32'd0);
    check("w1_y", {21'd0, col_y}, 32'd176);
    check("w1_gain_y", {21'd0, g_y}, 32'd0);
    @(negedge clk);
    check("w1_xfer_valid", {31'd0, col_valid}, 32'd0);
    check("w1_xfer_x", {21'd0, col_x}, 32'd1);
    check("w1_xfer_fd", {31'd0, frame_done}, 32'd0);

    // Window 2: mix-average of -2^23 -> 240+128 = 368; gain x4 clamps to 479.
    window4(24'h800000, 24'h800000);
    check("w2_x", {21'd0, col_x}, 32'd1);
    check("w2_y", {21'd0, col_y}, 32'd368);
    check("w2_gain_y", {21'd0, g_y}, 32'd479);
    @(negedge clk);

    // Window 3: mix-peak of 0, 2^20, |-2^22|, 2^21 -> 479-128 = 351; mode flips mid-window.
    mode = 2'b11;
    do_read(24'h000000, 24'h000000);
    mode = 2'b00;
    do_read(24'h100000, 24'h100000);
    do_read(24'hC00000, 24'hC00000);
    do_read(24'h200000, 24'h200000);
    check("w3_x", {21'd0, col_x}, 32'd2);
    check("w3_peak_y", {21'd0, col_y}, 32'd351);
    check("w3_gain_y", {21'd0, g_y}, 32'd0);
    @(negedge clk);

    // Window 4: left-average of 2^21 -> 208; its transfer wraps the frame.
    mode = 2'b01;
    window4(24'h200000, 24'h800000);
    check("w4_x", {21'd0, col_x}, 32'd3);
    check("w4_y", {21'd0, col_y}, 32'd208);
    check("w4_gain_y", {21'd0, g_y}, 32'd112);
    check("w4_fd_early", {31'd0, frame_done}, 32'd0);
    @(negedge clk);
    check("w4_fd", {31'd0, frame_done}, 32'd1);
    check("w4_gain_fd", {31'd0, g_frame_done}, 32'd1);
    check("w4_wrap_x", {21'd0, col_x}, 32'd0);
    @(negedge clk);
    check("w4_fd_pulse", {31'd0, frame_done}, 32'd0);

    // Windows 5/6 with ready low: right-average -2^22 -> 304 held, second result dropped.
    col_ready = 1'b0;
    mode = 2'b10;
    window4(24'h3FFFFF, 24'hC00000);
    check("w5_y", {21'd0, col_y}, 32'd304);
    check("w5_gain_y", {21'd0, g_y}, 32'd479);
    check("w5_ovr0", {31'd0, overrun}, 32'd0);
    mode = 2'b00;
    window4(24'h400000, 24'h400000);
    check("w6_held_y", {21'd0, col_y}, 32'd304);
    check("w6_held_x", {21'd0, col_x}, 32'd0);
    check("w6_ovr", {31'd0, overrun}, 32'd1);
    check("w6_gain_ovr", {31'd0, g_overrun}, 32'd1);
    col_ready = 1'b1;
    @(negedge clk);
    check("w6_absent", {31'd0, col_valid}, 32'd0);
    check("w6_x", {21'd0, col_x}, 32'd1);
    check("w6_ovr_sticky", {31'd0, overrun}, 32'd1);

    // Window 7 pending (zero -> 240), window 8 completes in the same cycle it transfers.
    col_ready = 1'b0;
    window4(24'h000000, 24'h000000);
    check("w7_y", {21'd0, col_y}, 32'd240);
    for (int i = 0; i < 3; i++) do_read(24'h200000, 24'h200000);
    @(negedge clk);
    audio_left = 24'h200000; audio_right = 24'h200000; read = 1'b1; col_ready = 1'b1;
    @(negedge clk);
    read = 1'b0;
    check("w8_valid", {31'd0, col_valid}, 32'd1);
    check("w8_x", {21'd0, col_x}, 32'd2);
    check("w8_y", {21'd0, col_y}, 32'd208);
    check("w8_gain_x", {21'd0, g_x}, 32'd2);
    @(negedge clk);
    check("w8_x_after", {21'd0, col_x}, 32'd3);

    // Window 9 pending (-2^21 -> 272); next window aborted by enable=0 on its last read.
    col_ready = 1'b0;
    window4(24'hE00000, 24'hE00000);
    check("w9_y", {21'd0, col_y}, 32'd272);
    for (int i = 0; i < 3; i++) do_read(24'h400000, 24'h400000);
    @(negedge clk);
    audio_left = 24'h400000; audio_right = 24'h400000; read = 1'b1; enable = 1'b0;
    @(negedge clk);
    read = 1'b0;
    check("abort_valid", {31'd0, col_valid}, 32'd1);
    check("abort_y", {21'd0, col_y}, 32'd272);
    check("abort_x", {21'd0, col_x}, 32'd3);
    col_ready = 1'b1;
    @(negedge clk);
    check("abort_fd", {31'd0, frame_done}, 32'd1);
    check("abort_x_wrap", {21'd0, col_x}, 32'd0);

    // Reads while idle produce nothing.
    window4(24'h400000, 24'h400000);
    @(negedge clk);
    check("idle_valid", {31'd0, col_valid}, 32'd0);

    // Window 10 transfers (x -> 1); window 11 pending, then reset after two partial reads.
    enable = 1'b1;
    @(negedge clk);
    window4(24'h400000, 24'h400000);
    check("w10_y", {21'd0, col_y}, 32'd176);
    @(negedge clk);
    col_ready = 1'b0;
    window4(24'h000000, 24'h000000);
    check("w11_x", {21'd0, col_x}, 32'd1);
    do_read(24'h400000, 24'h400000);
    do_read(24'h400000, 24'h400000);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, col_valid}, 32'd0);
    check("mid_rst_x", {21'd0, col_x}, 32'd0);
    check("mid_rst_y", {21'd0, col_y}, 32'd0);
    check("mid_rst_ovr", {31'd0, overrun}, 32'd0);
    check("mid_rst_fd", {31'd0, frame_done}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    col_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) do_read(24'h400000, 24'h400000);
    check("post_rst_partial", {31'd0, col_valid}, 32'd0);
    do_read(24'h400000, 24'h400000);
    check("post_rst_valid", {31'd0, col_valid}, 32'd1);
    check("post_rst_x", {21'd0, col_x}, 32'd0);
    check("post_rst_y", {21'd0, col_y}, 32'd176);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
